buffer_writer: RTL and testbench

Write-side counterpart of the buffer-read router: accepts packed `MaxWidth`-byte words from the compute array over a valid/ready handshake, unpacks each word into single bytes, and writes them sequentially into the single-port byte buffer over a contiguous, wrapping address range. It sits between the PE array output and the data buffer's write port. It signals completion once the byte at `finalAddr` has been issued.

---
 rtl/router_pkg.sv | 38 +++
 rtl/buffer_writer_if.sv | 41 ++++
 rtl/byte_lane_mux.sv | 22 ++
 rtl/buffer_writer.sv | 154 +++++++++++++++
 tb/tb_buffer_writer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the buffer read/write routers.
// Contents:
//   - geometry: MaxWidth bytes per packed word, Depth-byte buffer, DataWidth-bit bytes
//   - derived widths and the types built from them
//   - state_e: router FSM encoding (IDLE, LOAD, WRITE, DONE)
//   - next_addr(): increments a buffer address and wraps it at Depth
package router_pkg;

  localparam int MaxWidth  = 9;
  localparam int Depth     = 32;
  localparam int DataWidth = 8;
  localparam int AddrWidth = $clog2(Depth);
  localparam int LaneWidth = $clog2(MaxWidth);

  // Lane-slice helpers: lane i of a packed word sits at [i*DataWidth +: DataWidth].
  localparam int WordWidth = MaxWidth * DataWidth;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LaneWidth-1:0] lane_t;
  typedef logic [DataWidth-1:0] byte_t;
  typedef logic [WordWidth-1:0] word_t;
  typedef logic [MaxWidth-1:0]  mask_t;

  localparam lane_t LastLane = lane_t'(MaxWidth - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_e;

  // Depth need not be a power of two, so the wrap is explicit.
  function automatic addr_t next_addr(input addr_t a);
    return (a == addr_t'(Depth - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/buffer_writer_if.sv
// Handshake and buffer-port bundle for buffer_writer.
// Optional feature macro: BUFFER_WRITER_MASK_EN adds the byteMask signal.
// Modports:
//   master - the control/producer side: drives start, address range, word, valid
//            (and byteMask); observes ready, write strobes and status.
//   slave  - buffer_writer itself.
interface buffer_writer_if;
  import router_pkg::*;

  logic  writeStart;
  addr_t startAddr;
  addr_t finalAddr;
  word_t dataIn;
  logic  dataInValid;
  logic  dataInReady;
  logic  writeEn;
  addr_t writeAddr;
  byte_t dataOut;
  logic  busy;
  logic  finished;
`ifdef BUFFER_WRITER_MASK_EN
  mask_t byteMask;
`endif

  modport master (
    output writeStart, startAddr, finalAddr, dataIn, dataInValid,
`ifdef BUFFER_WRITER_MASK_EN
    output byteMask,
`endif
    input  dataInReady, writeEn, writeAddr, dataOut, busy, finished
  );

  modport slave (
    input  writeStart, startAddr, finalAddr, dataIn, dataInValid,
`ifdef BUFFER_WRITER_MASK_EN
    input  byteMask,
`endif
    output dataInReady, writeEn, writeAddr, dataOut, busy, finished
  );

endinterface

// File: rtl/byte_lane_mux.sv
// Combinational selection of one byte lane out of a packed MaxWidth-byte word.
// Ports:
//   word_i - packed word, lane i at [(i+1)*DataWidth-1 -: DataWidth]
//   lane_i - lane index; values >= MaxWidth select zero
//   byte_o - selected byte
module byte_lane_mux
  import router_pkg::*;
(
  input  word_t word_i,
  input  lane_t lane_i,
  output byte_t byte_o
);

  always_comb begin
    // NOTE: default assigned before the loop so no path leaves byte_o unassigned (no latch).
    byte_o = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (lane_i == lane_t'(i)) byte_o = word_i[i*DataWidth +: DataWidth];
    end
  end

endmodule

// File: rtl/buffer_writer.sv
// Unpacks MaxWidth-byte words from the compute array into sequential byte writes
// over a contiguous, wrapping range [startAddr .. finalAddr] of the byte buffer.
// Optional feature macro: BUFFER_WRITER_MASK_EN (per-lane byteMask gates writeEn).
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - buffer_writer_if.slave: start/range, word handshake, buffer write port, status
// All bus outputs are registered. They are computed from the next state, so the
// byte for a given lane appears in the same cycle the FSM is in that lane.
module buffer_writer
  import router_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  buffer_writer_if.slave bus
);

  state_e state_q, state_d;
  addr_t  addr_q,  addr_d;
  addr_t  final_q, final_d;
  lane_t  lane_q,  lane_d;
  word_t  hold_q,  hold_d;
`ifdef BUFFER_WRITER_MASK_EN
  mask_t  mask_q,  mask_d;
`endif

  logic   ready_q, ready_d;
  logic   wen_q,   wen_d;
  addr_t  waddr_q, waddr_d;
  byte_t  dout_q,  dout_d;
  logic   busy_q,  busy_d;
  logic   fin_q,   fin_d;

  byte_t  lane_byte;

  // Selecting from the next-state word lets lane 0 leave on the handshake edge itself.
  byte_lane_mux u_lane_mux (
    .word_i (hold_d),
    .lane_i (lane_d),
    .byte_o (lane_byte)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    final_d = final_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
`ifdef BUFFER_WRITER_MASK_EN
    mask_d  = mask_q;
`endif
    ready_d = 1'b0;
    busy_d  = busy_q;
    fin_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.writeStart) begin
          addr_d  = bus.startAddr;
          final_d = bus.finalAddr;
          busy_d  = 1'b1;
          ready_d = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        ready_d = 1'b1;
        if (bus.dataInValid && ready_q) begin
          hold_d  = bus.dataIn;
`ifdef BUFFER_WRITER_MASK_EN
          mask_d  = bus.byteMask;
`endif
          lane_d  = '0;
          ready_d = 1'b0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        // The final address ends the transfer even mid-word; leftover lanes are dropped.
        if (addr_q == final_q) begin
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          addr_d = next_addr(addr_q);
          if (lane_q == LastLane) begin
            ready_d = 1'b1;
            state_d = LOAD;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Address and data hold their last values outside WRITE; only the strobe matters.
`ifdef BUFFER_WRITER_MASK_EN
    wen_d = (state_d == WRITE) && mask_d[lane_d];
`else
    wen_d = (state_d == WRITE);
`endif
    waddr_d = (state_d == WRITE) ? addr_d    : waddr_q;
    dout_d  = (state_d == WRITE) ? lane_byte : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      final_q <= '0;
      lane_q  <= '0;
      hold_q  <= '0;
`ifdef BUFFER_WRITER_MASK_EN
      mask_q  <= '0;
`endif
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q <= state_d;
      addr_q  <= addr_d;
      final_q <= final_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
`ifdef BUFFER_WRITER_MASK_EN
      mask_q  <= mask_d;
`endif
      ready_q <= ready_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.dataInReady = ready_q;
  assign bus.writeEn     = wen_q;
  assign bus.writeAddr   = waddr_q;
  assign bus.dataOut     = dout_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = fin_q;

endmodule

// File: tb/tb_buffer_writer.sv
// Directed self-checking bench for buffer_writer.
// With BUFFER_WRITER_MASK_EN defined, a masked-word scenario is added.
module tb_buffer_writer;
  import router_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   errors;

  buffer_writer_if bus ();

  buffer_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk_word(input int base);
    word_t w;
    for (int i = 0; i < MaxWidth; i++) w[i*DataWidth +: DataWidth] = byte_t'(base + i);
    return w;
  endfunction

  task automatic start(input string tag, input int s, input int f);
    bus.writeStart = 1'b1;
    bus.startAddr  = addr_t'(s);
    bus.finalAddr  = addr_t'(f);
    tick();
    bus.writeStart = 1'b0;
    check({tag, " busy"},  32'(bus.busy), 1);
    check({tag, " ready"}, 32'(bus.dataInReady), 1);
    check({tag, " wen"},   32'(bus.writeEn), 0);
  endtask

  // Current cycle must present one buffer write.
  task automatic exp_write(input string tag, input int addr, input int data);
    check({tag, " wen"},   32'(bus.writeEn), 1);
    check({tag, " addr"},  32'(bus.writeAddr), addr);
    check({tag, " data"},  32'(bus.dataOut), data);
    check({tag, " ready"}, 32'(bus.dataInReady), 0);
  endtask

  // Current cycle must be the completion pulse; the next one must be quiet.
  task automatic exp_done(input string tag);
    check({tag, " fin"},   32'(bus.finished), 1);
    check({tag, " busy"},  32'(bus.busy), 0);
    check({tag, " wen"},   32'(bus.writeEn), 0);
    check({tag, " ready"}, 32'(bus.dataInReady), 0);
    tick();
    check({tag, " fin drop"},  32'(bus.finished), 0);
    check({tag, " wen after"}, 32'(bus.writeEn), 0);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst    = 1'b1;
    bus.writeStart  = 1'b0;
    bus.startAddr   = '0;
    bus.finalAddr   = '0;
    bus.dataIn      = '0;
    bus.dataInValid = 1'b0;
`ifdef BUFFER_WRITER_MASK_EN
    bus.byteMask    = '1;
`endif

    // ---- reset state ----
    #12;
    check("rst wen",   32'(bus.writeEn), 0);
    check("rst busy",  32'(bus.busy), 0);
    check("rst fin",   32'(bus.finished), 0);
    check("rst ready", 32'(bus.dataInReady), 0);
    check("rst addr",  32'(bus.writeAddr), 0);
    check("rst data",  32'(bus.dataOut), 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle busy",  32'(bus.busy), 0);
    check("idle ready", 32'(bus.dataInReady), 0);

    // ---- basic word: 0..8, bytes 0x01..0x09 ----
    start("basic start", 0, 8);
    bus.dataIn      = mk_word('h01);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_write($sformatf("basic lane%0d", i), i, 'h01 + i);
      tick();
    end
    exp_done("basic done");

    // ---- partial last word: 0..11, two words, valid held ----
    start("part start", 0, 11);
    bus.dataIn      = mk_word('h10);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataIn = mk_word('h20);
    for (int i = 0; i < 9; i++) begin
      exp_write($sformatf("part w1 lane%0d", i), i, 'h10 + i);
      tick();
    end
    check("part bubble wen",   32'(bus.writeEn), 0);
    check("part bubble ready", 32'(bus.dataInReady), 1);
    check("part bubble busy",  32'(bus.busy), 1);
    tick();
    bus.dataInValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_write($sformatf("part w2 lane%0d", i), 9 + i, 'h20 + i);
      tick();
    end
    exp_done("part done");

    // ---- wraparound: 30..1 ----
    start("wrap start", 30, 1);
    bus.dataIn      = mk_word('h40);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    exp_write("wrap a30", 30, 'h40); tick();
    exp_write("wrap a31", 31, 'h41); tick();
    exp_write("wrap a0",  0,  'h42); tick();
    exp_write("wrap a1",  1,  'h43); tick();
    exp_done("wrap done");

    // ---- backpressure and ignored start: 5..7 ----
    start("bp start", 5, 7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp stall%0d wen", i),   32'(bus.writeEn), 0);
      check($sformatf("bp stall%0d ready", i), 32'(bus.dataInReady), 1);
    end
    bus.dataIn      = mk_word('h50);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    exp_write("bp a5", 5, 'h50);
    bus.writeStart = 1'b1;
    bus.startAddr  = addr_t'(20);
    bus.finalAddr  = addr_t'(25);
    tick();
    bus.writeStart = 1'b0;
    exp_write("bp a6", 6, 'h51); tick();
    exp_write("bp a7", 7, 'h52); tick();
    exp_done("bp done");

    // ---- reset mid-transfer, then fresh single-byte transfer ----
    start("rmt start", 0, 20);
    bus.dataIn      = mk_word('h60);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_write($sformatf("rmt lane%0d", i), i, 'h60 + i);
      tick();
    end
    exp_write("rmt lane4", 4, 'h64);
    #2;
    rst = 1'b1;
    #1;
    check("rmt wen",   32'(bus.writeEn), 0);
    check("rmt busy",  32'(bus.busy), 0);
    check("rmt fin",   32'(bus.finished), 0);
    check("rmt ready", 32'(bus.dataInReady), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rmt no fin", 32'(bus.finished), 0);
    start("single start", 10, 10);
    bus.dataIn      = mk_word('h70);
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    exp_write("single a10", 10, 'h70);
    tick();
    exp_done("single done");

`ifdef BUFFER_WRITER_MASK_EN
    // ---- masked word: only even lanes written, same completion timing ----
    start("mask start", 0, 8);
    bus.dataIn      = mk_word('h80);
    bus.byteMask    = 9'b101010101;
    bus.dataInValid = 1'b1;
    tick();
    bus.dataInValid = 1'b0;
    bus.byteMask    = '1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("mask lane%0d wen", i),  32'(bus.writeEn), (i % 2 == 0) ? 1 : 0);
      check($sformatf("mask lane%0d addr", i), 32'(bus.writeAddr), i);
      tick();
    end
    exp_done("mask done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
